// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if
//   Bundles the fetch handshake and the write-back/status outputs of
//   multicycle_datapath.
//   master : instruction source (ROM side / test driver)
//            drives instr, instr_valid (and step)
//   slave  : the datapath
//            drives PC, wb_data, wb_valid, busy, retire_count
//   Signals
//     instr        8       instruction at address PC
//     instr_valid  1       instr is valid this cycle
//     PC           PC_W    current program counter
//     wb_data      DATA_W  last value written to the register file
//     wb_valid     1       high in the cycle a register write occurs
//     busy         1       high in every state except FETCH
//     retire_count CNT_W   completed instructions, wraps
//     step         1       present only when SINGLE_STEP_EN is defined
interface multicycle_datapath_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
);
  logic [7:0]        instr;
  logic              instr_valid;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              busy;
  logic [CNT_W-1:0]  retire_count;
`ifdef SINGLE_STEP_EN
  logic              step;

  modport master (
    output instr, instr_valid, step,
    input  PC, wb_data, wb_valid, busy, retire_count
  );

  modport slave (
    input  instr, instr_valid, step,
    output PC, wb_data, wb_valid, busy, retire_count
  );
`else
  modport master (
    output instr, instr_valid,
    input  PC, wb_data, wb_valid, busy, retire_count
  );

  modport slave (
    input  instr, instr_valid,
    output PC, wb_data, wb_valid, busy, retire_count
  );
`endif
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle implementation of the 2-bit-opcode ISA (ADD/LW/SW/J).
//   One instruction in flight, walked through FETCH/DECODE/EXEC/MEM/WB.
//   Latency from FETCH accept: J 3, ADD 4, SW 4, LW 5 cycles.
//   Instruction fields: op=[7:6] rs=[5:4] rt=[3:2] rd/imm=[1:0].
//
//   Ports
//     CLK    in  system clock, rising edge
//     RESET  in  asynchronous, active-high reset
//     bus    slave side of multicycle_datapath_if (fetch handshake in,
//            PC / wb_data / wb_valid / busy / retire_count out)
//
//   Configuration macro: SINGLE_STEP_EN
//     defined   : FETCH accepts only when instr_valid && step
//     undefined : FETCH accepts on instr_valid alone
//
//   state  | meaning
//   FETCH  | wait for an instruction, latch it into IR
//   DECODE | read rs/rt operands into A/B
//   EXEC   | ALU op; J updates PC and retires here
//   MEM    | SW writes DMEM and retires; LW reads into MDR
//   WB     | register write, PC+1, retire
module multicycle_datapath #(
  parameter int DATA_W     = 8,
  parameter int DMEM_DEPTH = 16,
  parameter int PC_W       = 8,
  parameter int CNT_W      = 16
) (
  input logic CLK,
  input logic RESET,
  multicycle_datapath_if.slave bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]        state;
  logic [7:0]        ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr, wb_data_q;
  logic [DATA_W-1:0] rf   [4];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  retire_count;

  logic [1:0]        op, rs, rt, rd;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] wb_value;
  logic [1:0]        wb_dest;
  logic              accept;
  logic              wb_now;

  assign op = ir[7:6];
  assign rs = ir[5:4];
  assign rt = ir[3:2];
  assign rd = ir[1:0];

  assign imm_d  = {{(DATA_W-2){ir[1]}}, ir[1:0]};
  assign imm_pc = {{(PC_W-2){ir[1]}}, ir[1:0]};

  // Address is the ALU result modulo DMEM_DEPTH (power of two).
  assign mem_addr = alu_out[AW-1:0];

  // ADD writes rd from the ALU, LW writes rt from MDR.
  assign wb_value = (op == OP_ADD) ? alu_out : mdr;
  assign wb_dest  = (op == OP_ADD) ? rd : rt;

`ifdef SINGLE_STEP_EN
  assign accept = bus.instr_valid && bus.step;
`else
  assign accept = bus.instr_valid;
`endif

  assign wb_now = (state == WB);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= FETCH;
      pc           <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      wb_data_q    <= '0;
      retire_count <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= DATA_W'(i);
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            ir    <= bus.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= EXEC;
        end
        EXEC: begin
          case (op)
            OP_ADD: begin
              alu_out <= a + b;
              state   <= WB;
            end
            OP_LW, OP_SW: begin
              alu_out <= a + imm_d;
              state   <= MEM;
            end
            default: begin
              pc           <= pc + PC_ONE + imm_pc;
              retire_count <= retire_count + CNT_ONE;
              state        <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (op == OP_SW) begin
            dmem[mem_addr] <= b;
            pc             <= pc + PC_ONE;
            retire_count   <= retire_count + CNT_ONE;
            state          <= FETCH;
          end else begin
            mdr   <= dmem[mem_addr];
            state <= WB;
          end
        end
        WB: begin
          rf[wb_dest]  <= wb_value;
          wb_data_q    <= wb_value;
          pc           <= pc + PC_ONE;
          retire_count <= retire_count + CNT_ONE;
          state        <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // wb_data shows the value being written during WB, then holds it.
  assign bus.wb_data      = wb_now ? wb_value : wb_data_q;
  assign bus.wb_valid     = wb_now;
  assign bus.busy         = (state != FETCH);
  assign bus.PC           = pc;
  assign bus.retire_count = retire_count;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath
//   Directed bench for multicycle_datapath. Two instances: an 8-bit datapath
//   for the main sequence and a 4-bit one for the modulo-16 ADD chain.
//   Expected write-back values are queued when an instruction is issued and
//   popped when wb_valid is seen. Honours SINGLE_STEP_EN.
module tb_multicycle_datapath;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  multicycle_datapath_if #(.DATA_W(8), .PC_W(8), .CNT_W(16)) bus8 ();
  multicycle_datapath_if #(.DATA_W(4), .PC_W(8), .CNT_W(16)) bus4 ();

  multicycle_datapath #(.DATA_W(8), .DMEM_DEPTH(16), .PC_W(8), .CNT_W(16)) u_dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  multicycle_datapath #(.DATA_W(4), .DMEM_DEPTH(16), .PC_W(8), .CNT_W(16)) u_dut4 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus4.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] q8 [$];
  logic [3:0] q4 [$];

  logic [7:0]  exp_pc;
  logic [15:0] exp_ret;
  logic [3:0]  m4 [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every register write must have been predicted.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && bus8.wb_valid === 1'b1) begin
      tests++;
      assert (q8.size() > 0) else begin
        fails++;
        $error("FAIL wb8_unexpected: observed wb_valid=1 wb_data=%0d expected no write", bus8.wb_data);
      end
      if (q8.size() > 0) check("wb8_data", bus8.wb_data, q8.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (RESET === 1'b0 && bus4.wb_valid === 1'b1) begin
      tests++;
      assert (q4.size() > 0) else begin
        fails++;
        $error("FAIL wb4_unexpected: observed wb_valid=1 wb_data=%0d expected no write", bus4.wb_data);
      end
      if (q4.size() > 0) check("wb4_data", bus4.wb_data, q4.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("rst_pc", bus8.PC, 0);
    check("rst_busy", bus8.busy, 0);
    tick();
    tick();
    RESET = 1'b0;
    exp_pc  = 8'd0;
    exp_ret = 16'd0;
  endtask

  // Issue one instruction on the 8-bit DUT and wait for it to retire.
  task automatic exec8(input logic [7:0] ins, input int lat, input string tag);
    int cyc;
    bus8.instr       = ins;
    bus8.instr_valid = 1'b1;
    tick();
    bus8.instr_valid = 1'b0;
    bus8.instr       = 8'($urandom);
    cyc = 1;
    while (bus8.busy === 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
  endtask

  task automatic exec4(input logic [7:0] ins, input string tag);
    int cyc;
    bus4.instr       = ins;
    bus4.instr_valid = 1'b1;
    tick();
    bus4.instr_valid = 1'b0;
    bus4.instr       = 8'($urandom);
    cyc = 1;
    while (bus4.busy === 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
  endtask

  initial begin
    bus8.instr       = 8'h00;
    bus8.instr_valid = 1'b0;
    bus4.instr       = 8'h00;
    bus4.instr_valid = 1'b0;
`ifdef SINGLE_STEP_EN
    bus8.step = 1'b1;
    bus4.step = 1'b1;
`endif
    RESET = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_retire", bus8.retire_count, 0);
    check("rst_wb_data", bus8.wb_data, 0);
    check("rst_wb_valid", bus8.wb_valid, 0);

    // Idle with instr_valid low: nothing moves
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", bus8.busy, 0);
      check("idle_pc", bus8.PC, 0);
      check("idle_retire", bus8.retire_count, 0);
      tick();
    end

    // ADD R3 = R1 + R2
    q8.push_back(8'd3);
    exec8(8'b00_01_10_11, 4, "add");
    check("add_pc", bus8.PC, 1);
    check("add_retire", bus8.retire_count, 1);
    check("add_wb_hold", bus8.wb_data, 3);

    // SW DMEM[R2] = R1, then LW R3 = DMEM[R2]
    exec8(8'b10_10_01_00, 4, "sw");
    check("sw_pc", bus8.PC, 2);
    q8.push_back(8'd1);
    exec8(8'b01_10_11_00, 5, "lw");
    check("lw_pc", bus8.PC, 3);
    check("lw_retire", bus8.retire_count, 3);

    // ADD R0 = R3 + R3 (same source twice) -> 2
    q8.push_back(8'd2);
    exec8(8'b00_11_11_00, 4, "add_same");
    // SW with negative offset: DMEM[R0 - 1] = DMEM[1] = R2 = 2
    exec8(8'b10_00_10_11, 4, "sw_neg");
    // LW R3 = DMEM[R1 + 0] = DMEM[1] = 2
    q8.push_back(8'd2);
    exec8(8'b01_01_11_00, 5, "lw_neg");
    check("seq_pc", bus8.PC, 6);
    check("seq_retire", bus8.retire_count, 6);
    check("seq_q8_empty", q8.size(), 0);

`ifdef SINGLE_STEP_EN
    // Single step: valid held high, step low holds FETCH
    do_reset();
    bus8.step        = 1'b0;
    bus8.instr       = 8'b00_01_10_11;
    bus8.instr_valid = 1'b1;
    q8.push_back(8'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("step_hold_busy", bus8.busy, 0);
      check("step_hold_pc", bus8.PC, 0);
    end
    bus8.step = 1'b1;
    tick();
    bus8.step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("step_retire", bus8.retire_count, 1);
    check("step_pc", bus8.PC, 1);
    check("step_busy", bus8.busy, 0);
    bus8.instr_valid = 1'b0;
    bus8.step        = 1'b1;
`endif

    // J +1 at PC 0 -> PC 2, J -1 at PC 0 -> PC 0
    do_reset();
    exec8(8'b11_00_00_01, 3, "j_fwd");
    check("j_fwd_pc", bus8.PC, 2);
    check("j_fwd_retire", bus8.retire_count, 1);
    do_reset();
    exec8(8'b11_00_00_11, 3, "j_self");
    check("j_self_pc", bus8.PC, 0);

    // PC wrap: 128 jumps of +2 from 0 come back to 0
    do_reset();
    for (int i = 0; i < 128; i++) begin
      exec8(8'b11_00_00_01, 3, "j_loop");
      exp_pc  = exp_pc + 8'd2;
      exp_ret = exp_ret + 16'd1;
    end
    check("j_wrap_pc", bus8.PC, exp_pc);
    check("j_wrap_retire", bus8.retire_count, exp_ret);

    // Reset during SW MEM: store must not land, PC back to 0
    do_reset();
    bus8.instr       = 8'b10_10_01_00;
    bus8.instr_valid = 1'b1;
    tick();
    bus8.instr_valid = 1'b0;
    tick();
    tick();
    check("mem_busy", bus8.busy, 1);
    RESET = 1'b1;
    #1;
    check("abort_pc", bus8.PC, 0);
    check("abort_busy", bus8.busy, 0);
    check("abort_retire", bus8.retire_count, 0);
    tick();
    RESET = 1'b0;
    q8.push_back(8'd0);
    exec8(8'b01_10_11_00, 5, "lw_after_abort");
    check("abort_lw_pc", bus8.PC, 1);
    check("abort_lw_retire", bus8.retire_count, 1);

    // 4-bit datapath: R0 = R3 + R3, then R0 = R0 + R3 six times
    m4[0] = 4'd0;
    m4[1] = 4'd1;
    m4[2] = 4'd2;
    m4[3] = 4'd3;
    for (int i = 0; i < 7; i++) begin
      logic [7:0] ins;
      logic [3:0] res;
      ins = (i == 0) ? 8'b00_11_11_00 : 8'b00_00_11_00;
      res = m4[ins[5:4]] + m4[ins[3:2]];
      m4[ins[1:0]] = res;
      q4.push_back(res);
      exec4(ins, "add4");
    end
    check("add4_final", bus4.wb_data, 8);
    check("add4_retire", bus4.retire_count, 7);

    tick();
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
